// File: rtl/fetcher_cached.sv
// Per-core instruction fetcher with a direct-mapped instruction buffer in front of program memory.
// Hits return in one cycle with no memory traffic. Misses issue one valid/ready read and fill the line.
module fetcher_cached #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8,
  parameter int COUNTER_BITS          = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);
  localparam int A     = PROGRAM_MEM_ADDR_BITS;
  localparam int D     = PROGRAM_MEM_DATA_BITS;
  localparam int C     = COUNTER_BITS;
  localparam int IDX   = $clog2(CACHE_LINES);
  // A buffer covering the whole address space leaves no tag bits; keep a constant-zero tag.
  localparam int TAG_W = (A > IDX) ? (A - IDX) : 1;

  localparam logic [2:0]   CORE_FETCH  = 3'b001;
  localparam logic [2:0]   CORE_DECODE = 3'b010;
  localparam logic [C-1:0] CNT_ONE     = C'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } state_e;

  state_e                 state_q;
  logic                   mem_read_valid_q;
  logic [A-1:0]           mem_read_address_q;
  logic [D-1:0]           instruction_q;
  logic [C-1:0]           hit_count_q, hit_count_d;
  logic [C-1:0]           miss_count_q, miss_count_d;
  logic [CACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
  logic [D-1:0]           data_q [CACHE_LINES];

  logic [IDX-1:0]   lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag, fill_tag;
  logic             lookup, lk_hit, fill_en;

  assign lk_idx   = current_pc[IDX-1:0];
  assign lk_tag   = TAG_W'(current_pc >> IDX);
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup   = (state_q == ST_IDLE) && (core_state == CORE_FETCH);

  // The outstanding request address identifies the line to fill.
  assign fill_idx = mem_read_address_q[IDX-1:0];
  assign fill_tag = TAG_W'(mem_read_address_q >> IDX);
  assign fill_en  = (state_q == ST_FETCHING) && mem_read_ready;

  assign hit_count_d  = (lookup && lk_hit && (hit_count_q != '1))
                        ? hit_count_q + CNT_ONE : hit_count_q;
  assign miss_count_d = (lookup && !lk_hit && (miss_count_q != '1))
                        ? miss_count_q + CNT_ONE : miss_count_q;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_idx] <= mem_read_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      instruction_q      <= '0;
      hit_count_q        <= '0;
      miss_count_q       <= '0;
      valid_q            <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      // Invalidate beats a same-cycle fill so the line stays empty.
      if (invalidate)   valid_q           <= '0;
      else if (fill_en) valid_q[fill_idx] <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lk_hit) begin
              instruction_q <= data_q[lk_idx];
              state_q       <= ST_FETCHED;
            end else begin
              mem_read_valid_q   <= 1'b1;
              mem_read_address_q <= current_pc;
              state_q            <= ST_FETCHING;
            end
          end
        end
        ST_FETCHING: begin
          if (mem_read_ready) begin
            instruction_q    <= mem_read_data;
            mem_read_valid_q <= 1'b0;
            state_q          <= ST_FETCHED;
          end
        end
        ST_FETCHED: begin
          if (core_state == CORE_DECODE) state_q <= ST_IDLE;
        end
        default: begin
          state_q          <= ST_IDLE;
          mem_read_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = mem_read_address_q;
  assign fetcher_state    = state_q;
  assign instruction      = instruction_q;
  assign hit_count        = hit_count_q;
  assign miss_count       = miss_count_q;
endmodule

// File: tb/tb_fetcher_cached.sv
// Bench for fetcher_cached: two configurations share one stimulus port set; sel picks the active one.
// A line-granular reference model (full PC compare per index) predicts hits, data and counters.
module tb_fetcher_cached;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] FETCH  = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;

  logic        reset_n;
  logic [2:0]  cs;
  logic [9:0]  pc;
  logic        inv, rdy;
  logic [31:0] rdata;
  int          sel;

  logic        v0, v1;
  logic [7:0]  a0;
  logic [9:0]  a1;
  logic [2:0]  s0, s1;
  logic [15:0] i0, h0, m0;
  logic [31:0] i1;
  logic [3:0]  h1, m1;

  fetcher_cached #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16),
                   .CACHE_LINES(8), .COUNTER_BITS(16)) u0 (
    .clk(clk), .reset_n(reset_n), .core_state((sel == 0) ? cs : 3'b000),
    .current_pc(pc[7:0]), .invalidate((sel == 0) & inv),
    .mem_read_valid(v0), .mem_read_address(a0), .mem_read_ready((sel == 0) & rdy),
    .mem_read_data(rdata[15:0]), .fetcher_state(s0), .instruction(i0),
    .hit_count(h0), .miss_count(m0));

  fetcher_cached #(.PROGRAM_MEM_ADDR_BITS(10), .PROGRAM_MEM_DATA_BITS(32),
                   .CACHE_LINES(16), .COUNTER_BITS(4)) u1 (
    .clk(clk), .reset_n(reset_n), .core_state((sel == 1) ? cs : 3'b000),
    .current_pc(pc), .invalidate((sel == 1) & inv),
    .mem_read_valid(v1), .mem_read_address(a1), .mem_read_ready((sel == 1) & rdy),
    .mem_read_data(rdata), .fetcher_state(s1), .instruction(i1),
    .hit_count(h1), .miss_count(m1));

  logic        o_vld;
  logic [9:0]  o_addr;
  logic [2:0]  o_st;
  logic [31:0] o_ins;
  logic [15:0] o_hit, o_miss;
  always_comb begin
    o_vld = v0; o_addr = {2'b00, a0}; o_st = s0; o_ins = {16'h0, i0}; o_hit = h0; o_miss = m0;
    if (sel == 1) begin
      o_vld = v1; o_addr = a1; o_st = s1; o_ins = i1; o_hit = {12'h0, h1}; o_miss = {12'h0, m1};
    end
  end

  int total = 0;
  int bad   = 0;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cfg %0d): got %0h expected %0h", n, sel, act, exp);
    end
  endtask

  // Reference model: per configuration, what each line holds and event counts.
  bit          m_v  [2][16];
  logic [9:0]  m_pc [2][16];
  logic [31:0] m_d  [2][16];
  int          m_hit[2], m_miss[2];

  function automatic int lines();  return (sel == 1) ? 16 : 8;                    endfunction
  function automatic logic [9:0]  amask(); return (sel == 1) ? 10'h3FF : 10'h0FF; endfunction
  function automatic logic [31:0] dmask(); return (sel == 1) ? 32'hFFFFFFFF : 32'h0000FFFF; endfunction
  function automatic int sat(input int c);
    int mx;
    mx = (sel == 1) ? 15 : 65535;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_clear(input int s);
    for (int i = 0; i < 16; i++) m_v[s][i] = 1'b0;
  endtask
  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      model_clear(s); m_hit[s] = 0; m_miss[s] = 0;
    end
  endtask

  // Full fetch transaction from IDLE back to IDLE; caller is at a falling edge.
  task automatic fetch(input logic [9:0] p_in, input logic [31:0] d_in, input int dly,
                       input bit inv_rdy, output bit got_hit, output logic [31:0] got_ins);
    logic [9:0]  p;
    logic [31:0] d;
    int          i;
    bit          eh;
    p  = p_in & amask();
    d  = d_in & dmask();
    i  = int'(p) % lines();
    eh = m_v[sel][i] && (m_pc[sel][i] == p);
    cs = FETCH; pc = p;
    @(negedge clk);
    cs = 3'b000;
    got_hit = (o_st == 3'b010);
    if (eh) begin
      m_hit[sel]++;
      check("hit_state", o_st, 3'b010);
      check("hit_no_req", o_vld, 1'b0);
      check("hit_instr", o_ins, m_d[sel][i]);
    end else begin
      m_miss[sel]++;
      check("miss_state", o_st, 3'b001);
      check("miss_req", {o_vld, o_addr}, {1'b1, p});
      for (int k = 0; k < dly; k++) begin
        @(negedge clk);
        check("req_hold", {o_vld, o_addr}, {1'b1, p});
      end
      rdata = $urandom; rdata = d | (rdata & ~dmask());
      rdy = 1'b1; inv = inv_rdy;
      @(negedge clk);
      rdy = 1'b0; inv = 1'b0; rdata = $urandom;
      check("fill_state", o_st, 3'b010);
      check("fill_instr", o_ins, d);
      check("req_drop", o_vld, 1'b0);
      if (inv_rdy) model_clear(sel);
      else begin
        m_v[sel][i] = 1'b1; m_pc[sel][i] = p; m_d[sel][i] = d;
      end
    end
    got_ins = o_ins;
    check("hit_count", o_hit, sat(m_hit[sel]));
    check("miss_count", o_miss, sat(m_miss[sel]));
    cs = DECODE;
    @(negedge clk);
    cs = 3'b000;
    check("back_idle", o_st, 3'b000);
  endtask

  typedef struct {
    int          cfg;
    logic [9:0]  pc;
    logic [31:0] data;
    int          dly;
    bit          hit;
    logic [31:0] ins;
    int          hits;
    int          misses;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          gh;
    logic [31:0] gi;
    tbl[0] = '{0, 10'h005, 32'h0000A1B2, 3, 1'b0, 32'h0000A1B2, 0, 1};
    tbl[1] = '{0, 10'h005, 32'h0000FFFF, 0, 1'b1, 32'h0000A1B2, 1, 1};
    tbl[2] = '{0, 10'h00D, 32'h00003C3C, 1, 1'b0, 32'h00003C3C, 1, 2};
    tbl[3] = '{0, 10'h005, 32'h00005A5A, 0, 1'b0, 32'h00005A5A, 1, 3};
    tbl[4] = '{0, 10'h005, 32'h00000000, 0, 1'b1, 32'h00005A5A, 2, 3};
    tbl[5] = '{1, 10'h205, 32'hA1B2C3D4, 3, 1'b0, 32'hA1B2C3D4, 0, 1};
    tbl[6] = '{1, 10'h205, 32'h00000000, 0, 1'b1, 32'hA1B2C3D4, 1, 1};
    tbl[7] = '{1, 10'h215, 32'h11112222, 1, 1'b0, 32'h11112222, 1, 2};
    tbl[8] = '{1, 10'h205, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1, 3};
    tbl[9] = '{1, 10'h205, 32'h00000000, 0, 1'b1, 32'hDEADBEEF, 2, 3};

    sel = 0; reset_n = 1'b0; cs = 3'b000; pc = '0; inv = 1'b0; rdy = 1'b0; rdata = '0;
    model_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      check("rst_state", o_st, 3'b000);
      check("rst_vld_addr", {o_vld, o_addr}, 11'h0);
      check("rst_instr", o_ins, 32'h0);
      check("rst_counts", {o_hit, o_miss}, 32'h0);
    end
    reset_n = 1'b1;
    sel = 0;
    @(negedge clk);

    // Cold miss, warm hit and index conflicts on both configurations.
    for (int k = 0; k < 10; k++) begin
      sel = tbl[k].cfg;
      fetch(tbl[k].pc, tbl[k].data, tbl[k].dly, 1'b0, gh, gi);
      check("vec_hit", gh, tbl[k].hit);
      check("vec_instr", gi, tbl[k].ins);
      check("vec_hits", o_hit, tbl[k].hits);
      check("vec_misses", o_miss, tbl[k].misses);
    end

    // Invalidate pulse in IDLE, then invalidate coincident with the fill.
    sel = 0;
    inv = 1'b1; @(negedge clk); inv = 1'b0; model_clear(0);
    fetch(10'h005, 32'h1234, 2, 1'b0, gh, gi);
    check("inv_then_miss", gh, 1'b0);
    fetch(10'h022, 32'h7777, 1, 1'b1, gh, gi);
    fetch(10'h022, 32'h8888, 0, 1'b0, gh, gi);
    check("inv_fill_miss", gh, 1'b0);

    // Invalidate during an IDLE lookup: the lookup still sees the old valid bit.
    cs = FETCH; pc = 10'h022; inv = 1'b1;
    @(negedge clk);
    cs = 3'b000; inv = 1'b0;
    m_hit[0]++; model_clear(0);
    check("inv_lookup_hit", o_st, 3'b010);
    check("inv_lookup_instr", o_ins, 32'h8888);
    check("inv_lookup_hits", o_hit, sat(m_hit[0]));
    cs = DECODE; @(negedge clk); cs = 3'b000;
    fetch(10'h022, 32'h9999, 0, 1'b0, gh, gi);
    check("inv_lookup_after", gh, 1'b0);

    // Reset while a request is outstanding; a late ready must be ignored.
    cs = FETCH; pc = 10'h040;
    @(negedge clk);
    cs = 3'b000;
    check("pre_rst_req", {o_vld, o_st}, {1'b1, 3'b001});
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_vld", o_vld, 1'b0);
    check("rst_async_state", o_st, 3'b000);
    @(negedge clk);
    reset_n = 1'b1; model_reset();
    rdy = 1'b1; rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rdy = 1'b0;
    check("late_ready_state", o_st, 3'b000);
    check("late_ready_vld", o_vld, 1'b0);
    check("late_ready_counts", {o_hit, o_miss}, 32'h0);
    fetch(10'h022, 32'h4321, 0, 1'b0, gh, gi);
    check("rst_cleared_valid", gh, 1'b0);

    // Hit counter saturation on the 4-bit configuration.
    sel = 1;
    fetch(10'h011, 32'h55, 0, 1'b0, gh, gi);
    for (int k = 0; k < 20; k++) fetch(10'h011, 32'h0, 0, 1'b0, gh, gi);
    check("sat_hit", o_hit, 16'h000F);
    check("sat_miss", o_miss, 16'h0001);

    // Randomized traffic with a narrow PC pool to force hits and conflicts.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int n = 0; n < 150; n++) begin
        logic [9:0] p;
        if ($urandom_range(0, 9) == 0) begin
          inv = 1'b1; @(negedge clk); inv = 1'b0; model_clear(s);
        end
        p = 10'($urandom_range(0, 2) * 64 + $urandom_range(0, 15));
        fetch(p, $urandom, $urandom_range(0, 3), $urandom_range(0, 9) == 0, gh, gi);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
